branch_resolve: RTL and testbench

Branch resolution and misprediction recovery unit, the consumer end of the 2-bit direction predictor. It carries each fetched instruction's predicted direction and PC alongside the core pipeline (IF/ID, ID/EX, EX/MEM) and compares the prediction with the actual outcome at MEM. On a mismatch it issues a one-cycle flush plus a redirect PC, and it kills younger in-flight predictions. It also keeps branch and mispredict statistics and flags prediction/pipeline desynchronisation.

---
 rtl/branch_resolve.sv | 120 ++++++++++++
 tb/tb_branch_resolve.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolution and misprediction recovery: carries predicted direction and PC
// alongside IF/ID, ID/EX, EX/MEM and checks each prediction against the outcome at MEM.
module branch_resolve #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic             if_pred_taken,
    input  logic             stall,
    input  logic             mem_branch,
    input  logic [31:0]      mem_pc,
    input  logic             mem_pcsrc,
    input  logic [31:0]      mem_target,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             sync_err
);

    logic        s1_valid_r, s2_valid_r, s3_valid_r;
    logic        s1_pred_r,  s2_pred_r,  s3_pred_r;
    logic [31:0] s1_pc_r,    s2_pc_r,    s3_pc_r;

    logic        res_s;
    logic        mispredict_s;
    logic        desync_s;
    logic [31:0] correct_pc_s;

    // Resolve the branch sitting in EX/MEM against its actual outcome
    always_comb begin
        res_s        = mem_branch & s3_valid_r;
        mispredict_s = res_s & (s3_pred_r != mem_pcsrc);
        desync_s     = res_s & (s3_pc_r != mem_pc);
        if (mem_pcsrc) begin
            correct_pc_s = mem_target;
        end else begin
            correct_pc_s = mem_pc + 32'd4;
        end
    end

    // Prediction pipeline shadowing the core's stage registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s3_valid_r <= 1'b0;
            s1_pred_r  <= 1'b0;
            s2_pred_r  <= 1'b0;
            s3_pred_r  <= 1'b0;
            s1_pc_r    <= 32'd0;
            s2_pc_r    <= 32'd0;
            s3_pc_r    <= 32'd0;
        end else begin
            // EX/MEM always advances; a stall only freezes IF/ID and bubbles ID/EX
            s3_valid_r <= s2_valid_r;
            s3_pred_r  <= s2_pred_r;
            s3_pc_r    <= s2_pc_r;
            if (stall) begin
                s2_valid_r <= 1'b0;
            end else begin
                s2_valid_r <= s1_valid_r;
                s2_pred_r  <= s1_pred_r;
                s2_pc_r    <= s1_pc_r;
                s1_valid_r <= if_valid & ~flush;
                s1_pred_r  <= if_pred_taken;
                s1_pc_r    <= if_pc;
            end
            // Later assignments win: a mispredict kills every younger prediction
            if (mispredict_s) begin
                s1_valid_r <= 1'b0;
                s2_valid_r <= 1'b0;
                s3_valid_r <= 1'b0;
            end
        end
    end

    // One-cycle flush/redirect pulse; redirect_pc keeps the last correction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            flush          <= mispredict_s;
            redirect_valid <= mispredict_s;
            if (mispredict_s) begin
                redirect_pc <= correct_pc_s;
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            branch_count     <= {CNT_W{1'b0}};
            mispredict_count <= {CNT_W{1'b0}};
        end else begin
            if (res_s && (branch_count != {CNT_W{1'b1}})) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (mispredict_s && (mispredict_count != {CNT_W{1'b1}})) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

    // Sticky desynchronisation flag, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_err <= 1'b0;
        end else if (desync_s) begin
            sync_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random traffic,
// compared against a queue-free behavioural model of the prediction pipeline.
module tb_branch_resolve;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        stall;
    logic        mem_branch;
    logic [31:0] mem_pc;
    logic        mem_pcsrc;
    logic [31:0] mem_target;

    logic        flush, redirect_valid, sync_err;
    logic [31:0] redirect_pc, branch_count, mispredict_count;
    logic        flush4, redirect_valid4, sync_err4;
    logic [31:0] redirect_pc4;
    logic [3:0]  branch_count4, mispredict_count4;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: entry [0]=IF/ID, [1]=ID/EX, [2]=EX/MEM
    logic        m_v [3];
    logic        m_p [3];
    logic [31:0] m_pc[3];
    logic        m_flush, m_rv, m_sync;
    logic [31:0] m_rpc;
    int          m_bc, m_mc;

    branch_resolve #(.CNT_W(32)) dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .stall(stall), .mem_branch(mem_branch),
        .mem_pc(mem_pc), .mem_pcsrc(mem_pcsrc), .mem_target(mem_target),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count),
        .sync_err(sync_err)
    );

    branch_resolve #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .stall(stall), .mem_branch(mem_branch),
        .mem_pc(mem_pc), .mem_pcsrc(mem_pcsrc), .mem_target(mem_target),
        .flush(flush4), .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
        .branch_count(branch_count4), .mispredict_count(mispredict_count4),
        .sync_err(sync_err4)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat4(input int v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0; m_p[i] = 1'b0; m_pc[i] = 32'd0;
        end
        m_flush = 1'b0; m_rv = 1'b0; m_sync = 1'b0; m_rpc = 32'd0;
        m_bc = 0; m_mc = 0;
    endtask

    // Apply the rules for one rising edge using the inputs currently driven
    task automatic model_edge();
        logic        res, mis, old_flush;
        logic [31:0] cpc;
        res = mem_branch && m_v[2];
        mis = res && (m_p[2] != mem_pcsrc);
        cpc = mem_pcsrc ? mem_target : mem_pc + 32'd4;
        if (res) m_bc++;
        if (mis) m_mc++;
        if (res && (m_pc[2] != mem_pc)) m_sync = 1'b1;
        old_flush = m_flush;
        m_v[2] = m_v[1]; m_p[2] = m_p[1]; m_pc[2] = m_pc[1];
        if (stall) begin
            m_v[1] = 1'b0;
        end else begin
            m_v[1] = m_v[0]; m_p[1] = m_p[0]; m_pc[1] = m_pc[0];
            m_v[0] = if_valid && !old_flush; m_p[0] = if_pred_taken; m_pc[0] = if_pc;
        end
        if (mis) begin
            for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
            m_flush = 1'b1; m_rv = 1'b1; m_rpc = cpc;
        end else begin
            m_flush = 1'b0; m_rv = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("flush", {31'd0, flush}, {31'd0, m_flush});
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("branch_count", branch_count, 32'(m_bc));
        chk("mispredict_count", mispredict_count, 32'(m_mc));
        chk("sync_err", {31'd0, sync_err}, {31'd0, m_sync});
        chk("flush4", {31'd0, flush4}, {31'd0, m_flush});
        chk("branch_count4", {28'd0, branch_count4}, sat4(m_bc));
        chk("mispredict_count4", {28'd0, mispredict_count4}, sat4(m_mc));
    endtask

    task automatic cyc(input logic ifv, input logic [31:0] ipc, input logic ipred,
                       input logic stl, input logic mb, input logic [31:0] mpc,
                       input logic msrc, input logic [31:0] mtgt);
        if_valid = ifv; if_pc = ipc; if_pred_taken = ipred; stall = stl;
        mem_branch = mb; mem_pc = mpc; mem_pcsrc = msrc; mem_target = mtgt;
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        if_valid = 1'b0; if_pc = 32'd0; if_pred_taken = 1'b0; stall = 1'b0;
        mem_branch = 1'b0; mem_pc = 32'd0; mem_pcsrc = 1'b0; mem_target = 32'd0;
        model_reset();
        #3;
        check_all();
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;

        // Correctly predicted not-taken branch
        cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle();
        idle();
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h200);
        chk("t1_bc", branch_count, 32'd1);
        chk("t1_noflush", {31'd0, flush}, 32'd0);

        // Predicted not taken, actually taken
        cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle();
        idle();
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200);
        chk("t2_flush", {31'd0, flush}, 32'd1);
        chk("t2_rpc", redirect_pc, 32'h200);
        chk("t2_mc", mispredict_count, 32'd1);
        idle();
        chk("t2_flush_drop", {31'd0, flush}, 32'd0);

        // Predicted taken, actually not taken; younger entries killed
        cyc(1'b1, 32'h1FC, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cyc(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cyc(1'b1, 32'h208, 1'b0, 1'b0, 1'b1, 32'h1FC, 1'b0, 32'h500);
        chk("t3_rpc", redirect_pc, 32'h200);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h204, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h208, 1'b0, 32'd0);
        chk("t3_killed", branch_count, 32'd3);

        // Stall: branch held in IF/ID, bubbles in; counted exactly once
        cyc(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'd0);
        chk("t4_not_yet", branch_count, 32'd3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'd0);
        chk("t4_once", branch_count, 32'd4);

        // PC desync: stored 0x104, MEM reports 0x108
        cyc(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle();
        idle();
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h108, 1'b0, 32'h900);
        chk("t5_sync", {31'd0, sync_err}, 32'd1);
        chk("t5_rpc", redirect_pc, 32'h10C);
        for (int i = 0; i < 4; i++) idle();
        chk("t5_sticky", {31'd0, sync_err}, 32'd1);

        // Back-to-back correct branches saturate the narrow counters
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0, (i >= 3),
                32'h400 + 32'(4 * (i - 3)), 1'b0, 32'd0);
        chk("t6_bc", branch_count, 32'd22);
        chk("t6_sat4", {28'd0, branch_count4}, 32'hF);

        // Asynchronous reset while flush is high
        cyc(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle();
        idle();
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 32'h600);
        chk("t7_flush", {31'd0, flush}, 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t7_async_flush", {31'd0, flush}, 32'd0);
        check_all();
        #2 reset = 1'b0;

        // Fall-through wraps at the top of the address space
        cyc(1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle();
        idle();
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h700);
        chk("t8_wrap", redirect_pc, 32'h0);
        chk("t8_rv", {31'd0, redirect_valid}, 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] mpc;
            mpc = ($urandom_range(3) != 0) ? m_pc[2] : {$urandom_range(255), 2'b00};
            cyc(1'($urandom_range(1)), {$urandom_range(1023), 2'b00}, 1'($urandom_range(1)),
                ($urandom_range(4) == 0), ($urandom_range(2) != 0), mpc,
                1'($urandom_range(1)), {$urandom_range(4095), 2'b00});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
